data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Bus-side responder for the LEGv8 datapath: a word-addressed 64-bit data memory.
- The CPU-side controller asserts a request with a 32-bit byte address and, for writes, 64-bit write data. After a fixed number of wait states the responder completes the access.
- Completion is signalled with a one-cycle ready pulse. On reads, the block returns data plus an output-enable; the parent uses that enable to drive the shared tristate data bus.

Parameters:
- ADDR_WIDTH, 8, number of doubleword index bits; depth = 2**ADDR_WIDTH words of 64 bits.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and completion (0 allowed).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  access request, sampled only in IDLE.
- rw  input  1  1 = write, 0 = read; sampled with req.
- address  input  32  byte address from the address bus.
- wdata  input  64  write data from the data bus; sampled with req.
- rdata  output  64  read data.
- data_oe  output  1  parent drives the data bus with rdata while high.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from acceptance until the ready cycle, inclusive.
- error  output  1  misaligned access flag; only meaningful when MEM_ALIGN_CHECK_EN is defined.

Behaviour:
- Reset values:
  - State IDLE.
  - rdata = 0, data_oe = 0, ready = 0, busy = 0, error = 0, wait counter = 0.
  - Memory array contents are not reset.
- States and transitions:
  - IDLE: on req = 1, latch rw, address and wdata; load counter = WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, else to ACCESS.
  - WAIT: decrement the counter each cycle; go to ACCESS when the counter reaches 1.
  - ACCESS: one cycle.
    - Write: mem[index] <= latched wdata at the exit edge.
    - Read: rdata <= mem[index] at the exit edge.
    - Then go to RESP.
  - RESP: one cycle. ready = 1. data_oe = 1 only for reads. Return to IDLE.
- Latency: with req accepted at edge k, ready is high during the cycle after edge k + WAIT_CYCLES + 1.
  - Total: WAIT_CYCLES + 2 cycles from accept to ready.
- Word index: index = address[ADDR_WIDTH+2:3]. Bits above the index alias (wrap modulo depth). address[2:0] is ignored unless the optional feature is on.
- busy:
  - Combinationally high in WAIT, ACCESS and RESP.
  - Registered high from the accept edge, so busy is high in the cycle after req is sampled.
- req while busy: ignored, not queued. The requester must hold req low or re-issue after ready.
- req high in the RESP cycle: not accepted. Acceptance only happens in IDLE, the cycle after ready at the earliest.
- Read-after-write to the same index: returns the new data.
- data_oe: high only in RESP for reads; low in every other cycle, including write RESP. There is never contention with CPU drives outside RESP.
- rdata: holds its last read value until the next read's ACCESS exit edge.
- Reset mid-operation: returns to IDLE immediately and clears all outputs.
  - A write whose ACCESS edge coincides with the reset edge is not committed; reset has priority.
- error: low except as defined below.

Optional Feature:
- MEM_ALIGN_CHECK_EN
- Defined:
  - An accepted request with address[2:0] != 0 still passes through WAIT and ACCESS.
  - A misaligned write does not modify memory.
  - A misaligned read returns rdata = 0.
  - In RESP, ready = 1 and error = 1; error is high only in that cycle.
  - data_oe follows the normal read rule.
- Not defined:
  - address[2:0] is ignored.
  - error is tied to 0.

Test Plan:
- Reset, then write: ADDR_WIDTH = 8, WAIT_CYCLES = 2. Write req at address 0x0000_0010, wdata 0xDEAD_BEEF_0123_4567.
  - ready pulses exactly 4 cycles after the accept edge; data_oe stays 0; busy is high for 4 cycles.
- Read back address 0x10: rdata = 0xDEAD_BEEF_0123_4567 with data_oe = 1 in the ready cycle only.
- Aliasing: write 0x1111 to address 0x0000_0808 (index 1, bit 11 aliases), then read address 0x0000_0008.
  - Returns 0x1111.
- Back-to-back: hold req high across a read.
  - The second request is accepted only in the IDLE cycle after ready.
  - No acceptance during busy; exactly one extra completion occurs.
- WAIT_CYCLES = 0: write then read at address 0x18.
  - Each access gives ready 2 cycles after accept; readback is correct.
- Reset asserted in WAIT of a write of 0xAAAA to address 0x20.
  - Outputs clear the next cycle.
  - A subsequent read of 0x20 returns the prior contents, not 0xAAAA.
  - With MEM_ALIGN_CHECK_EN: a read at 0x21 gives ready = 1, error = 1, rdata = 0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Word-addressed 64-bit data memory responder with fixed wait states and a one-cycle ready pulse.
// Optional misaligned-access detection is enabled by defining MEM_ALIGN_CHECK_EN.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [31:0] address,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        data_oe,
  output logic        ready,
  output logic        busy,
  output logic        error,
  output logic [1:0]  state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic                  rw_q;
  logic [31:0]           addr_q;
  logic [63:0]           wdata_q;
  logic [63:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  misaligned;

  // Upper address bits alias onto the array; they are intentionally dropped.
  assign idx = addr_q[ADDR_WIDTH+2:3];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (addr_q[2:0] != 3'b000);
  logic unused_addr;
  assign unused_addr = ^addr_q[31:ADDR_WIDTH+3];
`else
  assign misaligned = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{addr_q[31:ADDR_WIDTH+3], addr_q[2:0]};
`endif

  // Valid/ready: req is sampled only in IDLE; ready is a one-cycle completion
  // pulse, busy covers acceptance through the ready cycle, and requests seen
  // while busy (including the ready cycle) are dropped, not queued.
  assign busy      = (state != S_IDLE);
  assign ready     = (state == S_RESP);
  assign data_oe   = (state == S_RESP) && !rw_q;
  assign error     = (state == S_RESP) && misaligned;
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            rw_q    <= rw;
            addr_q  <= address;
            wdata_q <= wdata;
            cnt     <= CW'(WAIT_CYCLES);
            state   <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!rw_q) rdata <= misaligned ? 64'd0 : mem[idx];
          state <= S_RESP;
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory has no reset; a write landing on a reset edge is discarded.
  always_ff @(posedge clock) begin
    if (!reset && (state == S_ACCESS) && rw_q && !misaligned)
      mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2 wait states and 0 wait states)
// checked every cycle against a timing/array model, plus directed literal checks.
module tb_data_memory_responder;

  localparam int AW = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        rw [2];
  logic [31:0] address [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata_o [2];
  logic        data_oe_o [2];
  logic        ready_o [2];
  logic        busy_o [2];
  logic        error_o [2];
  logic [1:0]  state_o [2];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u0 (
    .clock(clock), .reset(reset), .req(req[0]), .rw(rw[0]), .address(address[0]),
    .wdata(wdata[0]), .rdata(rdata_o[0]), .data_oe(data_oe_o[0]), .ready(ready_o[0]),
    .busy(busy_o[0]), .error(error_o[0]), .state_dbg(state_o[0])
  );

  data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u1 (
    .clock(clock), .reset(reset), .req(req[1]), .rw(rw[1]), .address(address[1]),
    .wdata(wdata[1]), .rdata(rdata_o[1]), .data_oe(data_oe_o[1]), .ready(ready_o[1]),
    .busy(busy_o[1]), .error(error_o[1]), .state_dbg(state_o[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ph counts edges since acceptance (0 = idle); ready when ph == wait+2.
  int          ph [2] = '{0, 0};
  logic        l_rw [2];
  logic [31:0] l_addr [2];
  logic [63:0] l_wdata [2];
  logic [63:0] m_rdata [2];
  logic        m_rvalid [2] = '{1'b0, 1'b0};
  logic        m_mis [2] = '{1'b0, 1'b0};
  logic [63:0] sh [2][256];
  logic        kn [2][256];
  bit          live = 1'b0;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) kn[d][i] = 1'b0;
  end

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      int w;
      int ix;
      w = wait_of(d);
      if (reset) begin
        live = 1'b1;
        ph[d] = 0;
        m_rdata[d] = 64'd0;
        m_rvalid[d] = 1'b1;
        m_mis[d] = 1'b0;
      end else if (ph[d] == 0) begin
        if (req[d]) begin
          ph[d] = 1;
          l_rw[d] = rw[d];
          l_addr[d] = address[d];
          l_wdata[d] = wdata[d];
        end
      end else if (ph[d] == w + 2) begin
        ph[d] = 0;
      end else begin
        if (ph[d] == w + 1) begin
          ix = int'(l_addr[d][AW+2:3]);
`ifdef MEM_ALIGN_CHECK_EN
          m_mis[d] = (l_addr[d] % 8) != 0;
`else
          m_mis[d] = 1'b0;
`endif
          if (l_rw[d]) begin
            if (!m_mis[d]) begin
              sh[d][ix] = l_wdata[d];
              kn[d][ix] = 1'b1;
            end
          end else if (m_mis[d]) begin
            m_rdata[d] = 64'd0;
            m_rvalid[d] = 1'b1;
          end else begin
            m_rdata[d] = sh[d][ix];
            m_rvalid[d] = kn[d][ix];
          end
        end
        ph[d] = ph[d] + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (live) begin
      for (int d = 0; d < 2; d++) begin
        logic e_ready;
        e_ready = (ph[d] == wait_of(d) + 2);
        chk($sformatf("busy%0d", d), 64'(busy_o[d]), 64'(ph[d] != 0));
        chk($sformatf("ready%0d", d), 64'(ready_o[d]), 64'(e_ready));
        chk($sformatf("data_oe%0d", d), 64'(data_oe_o[d]), 64'(e_ready && !l_rw[d]));
        chk($sformatf("error%0d", d), 64'(error_o[d]), 64'(e_ready && m_mis[d]));
        if (m_rvalid[d]) chk($sformatf("rdata%0d", d), rdata_o[d], m_rdata[d]);
      end
    end
  end

  // One access on instance d; noise scrambles inputs while the DUT is busy.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [63:0] wd,
                        input bit noise, output logic [63:0] rd, output int lat);
    lat = 0;
    rd = '0;
    @(negedge clock);
    for (int i = 0; i < 50 && busy_o[d]; i++) @(negedge clock);
    if (busy_o[d]) chk("idle_timeout", 64'(busy_o[d]), 64'd0);
    req[d] = 1'b1;
    rw[d] = w;
    address[d] = a;
    wdata[d] = wd;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (ready_o[d]) begin
        lat = n;
        rd = rdata_o[d];
        req[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        break;
      end
      if (noise) begin
        req[d] = 1'($urandom_range(0, 1));
        rw[d] = 1'($urandom_range(0, 1));
        address[d] = $urandom;
        wdata[d] = {$urandom, $urandom};
      end else begin
        req[d] = 1'b0;
      end
    end
    if (lat == 0) chk("ready_timeout", 64'd0, 64'd1);
    @(negedge clock);
    req[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    int lat;
    int nready;
    int pos [2];
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0;
      rw[d] = 1'b0;
      address[d] = '0;
      wdata[d] = '0;
    end
    repeat (3) @(negedge clock);
    chk("rst_ready", 64'(ready_o[0]), 64'd0);
    chk("rst_busy", 64'(busy_o[0]), 64'd0);
    chk("rst_oe", 64'(data_oe_o[0]), 64'd0);
    chk("rst_error", 64'(error_o[0]), 64'd0);
    chk("rst_rdata", rdata_o[0], 64'd0);
    reset = 1'b0;

    access(0, 1'b1, 32'h0000_0010, 64'hDEAD_BEEF_0123_4567, 1'b0, rd, lat);
    chk("wr_latency", 64'(lat), 64'd4);
    access(0, 1'b0, 32'h0000_0010, 64'd0, 1'b0, rd, lat);
    chk("rd_latency", 64'(lat), 64'd4);
    chk("rd_data", rd, 64'hDEAD_BEEF_0123_4567);

    access(0, 1'b1, 32'h0000_0808, 64'h1111, 1'b0, rd, lat);
    access(0, 1'b0, 32'h0000_0008, 64'd0, 1'b0, rd, lat);
    chk("alias_data", rd, 64'h1111);

    // req held high across a read: second accept only after ready.
    @(negedge clock);
    req[0] = 1'b1;
    rw[0] = 1'b0;
    address[0] = 32'h0000_0010;
    nready = 0;
    pos[0] = 0;
    pos[1] = 0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clock);
      if (n == 6) req[0] = 1'b0;
      if (ready_o[0]) begin
        if (nready < 2) pos[nready] = n;
        nready++;
      end
    end
    chk("b2b_count", 64'(nready), 64'd2);
    chk("b2b_first", 64'(pos[0]), 64'd4);
    chk("b2b_second", 64'(pos[1]), 64'd9);

    access(1, 1'b1, 32'h0000_0018, 64'h0123_4567_89AB_CDEF, 1'b0, rd, lat);
    chk("w0_wr_latency", 64'(lat), 64'd2);
    access(1, 1'b0, 32'h0000_0018, 64'd0, 1'b0, rd, lat);
    chk("w0_rd_latency", 64'(lat), 64'd2);
    chk("w0_rd_data", rd, 64'h0123_4567_89AB_CDEF);

    // Reset during WAIT of a write.
    access(0, 1'b1, 32'h0000_0020, 64'h5555, 1'b0, rd, lat);
    @(negedge clock);
    req[0] = 1'b1;
    rw[0] = 1'b1;
    address[0] = 32'h0000_0020;
    wdata[0] = 64'hAAAA;
    @(negedge clock);
    req[0] = 1'b0;
    chk("mid_busy", 64'(busy_o[0]), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_busy", 64'(busy_o[0]), 64'd0);
    chk("rst_mid_ready", 64'(ready_o[0]), 64'd0);
    chk("rst_mid_rdata", rdata_o[0], 64'd0);
    reset = 1'b0;
    access(0, 1'b0, 32'h0000_0020, 64'd0, 1'b0, rd, lat);
    chk("rst_keep_data", rd, 64'h5555);

    // Reset on the ACCESS edge of a zero-wait write.
    access(1, 1'b1, 32'h0000_0028, 64'h7777, 1'b0, rd, lat);
    @(negedge clock);
    req[1] = 1'b1;
    rw[1] = 1'b1;
    address[1] = 32'h0000_0028;
    wdata[1] = 64'hBBBB;
    @(negedge clock);
    req[1] = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    access(1, 1'b0, 32'h0000_0028, 64'd0, 1'b0, rd, lat);
    chk("rst_access_data", rd, 64'h7777);

`ifdef MEM_ALIGN_CHECK_EN
    access(0, 1'b0, 32'h0000_0021, 64'd0, 1'b0, rd, lat);
    chk("mis_rdata", rd, 64'd0);
    chk("mis_latency", 64'(lat), 64'd4);
`endif

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        logic [31:0] a;
        a = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 15)) << 3)
            | 32'($urandom_range(0, 7));
        access(d, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 1'b1, rd, lat);
        chk($sformatf("rand_latency%0d", d), 64'(lat), 64'(wait_of(d) + 2));
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end

    repeat (4) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
